clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_ctrl_if.sv | 20 ++
 rtl/clk_div_core.sv | 36 +++
 rtl/clk_div_ctrl.sv | 114 +++++++++++
 tb/tb_clk_div_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and default settings for the clock divider controller.
package clk_div_pkg;

   localparam int DEFAULT_CNT_W  = 8;
   localparam int DEFAULT_PERIOD = 5;
   localparam int DEFAULT_DUTY   = 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PEND
   } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bus: period/duty offer with ready and reject pulse.
interface clk_div_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_duty;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_period, cfg_duty,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_period, cfg_duty,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/clk_div_core.sv
// Period counter with wrap, end-of-period tick and duty decode of the divided clock.
module clk_div_core #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             active,
   input  logic [CNT_W-1:0] period_r,
   input  logic [CNT_W-1:0] duty_r,
   output logic             tick,
   output logic             div_out
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last;

   assign last = period_r - CNT_W'(1);

   // Held at zero while idle so every run starts a fresh period; the >= guard
   // keeps cnt bounded even if the period ever shrinks under it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!active) begin
         cnt <= '0;
      end else if (cnt >= last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick    = active && (cnt == last);
   assign div_out = active && (cnt < duty_r);

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: run/pend FSM, config handshake and validation.
module clk_div_ctrl #(
   parameter int CNT_W      = clk_div_pkg::DEFAULT_CNT_W,
   parameter int DEF_PERIOD = clk_div_pkg::DEFAULT_PERIOD,
   parameter int DEF_DUTY   = clk_div_pkg::DEFAULT_DUTY
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   clk_div_ctrl_if.slave  cfg,
   output logic           div_out,
   output logic           tick,
   output logic           running
);
   import clk_div_pkg::*;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] period_r;
   logic [CNT_W-1:0] duty_r;
   logic [CNT_W-1:0] per_s;
   logic [CNT_W-1:0] duty_s;
   logic             rdy_en;
   logic             err_r;
   logic             cfg_ok;
   logic             accept;
   logic             load_active;
   logic             load_shadow;
   logic             apply_shadow;

   assign cfg_ok        = (cfg.cfg_period >= CNT_W'(2)) && (cfg.cfg_duty <= cfg.cfg_period);
   assign cfg.cfg_ready = rdy_en && (state != PEND);
   assign accept        = cfg.cfg_valid && cfg.cfg_ready && cfg_ok;
   assign cfg.cfg_err   = err_r;
   assign running       = (state != IDLE);

   // Next state and register-load decisions; a config landing on the final
   // tick of a stopping run goes straight to the active registers.
   always_comb begin
      state_nx     = state;
      load_active  = 1'b0;
      load_shadow  = 1'b0;
      apply_shadow = 1'b0;
      case (state)
         IDLE: begin
            load_active = accept;
            if (en) state_nx = RUN;
         end
         RUN: begin
            if (tick && !en) begin
               state_nx    = IDLE;
               load_active = accept;
            end else if (accept) begin
               state_nx    = PEND;
               load_shadow = 1'b1;
            end
         end
         PEND: begin
            if (tick) begin
               apply_shadow = 1'b1;
               state_nx     = en ? RUN : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // rdy_en keeps cfg_ready low through reset and for no longer than one edge after.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         rdy_en <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         state  <= state_nx;
         rdy_en <= 1'b1;
         err_r  <= cfg.cfg_valid && cfg.cfg_ready && !cfg_ok;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_r <= CNT_W'(DEF_PERIOD);
         duty_r   <= CNT_W'(DEF_DUTY);
         per_s    <= '0;
         duty_s   <= '0;
      end else begin
         if (load_active) begin
            period_r <= cfg.cfg_period;
            duty_r   <= cfg.cfg_duty;
         end else if (apply_shadow) begin
            period_r <= per_s;
            duty_r   <= duty_s;
         end
         if (load_shadow) begin
            per_s  <= cfg.cfg_period;
            duty_s <= cfg.cfg_duty;
         end
      end
   end

   clk_div_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .active   (state != IDLE),
      .period_r (period_r),
      .duty_r   (duty_r),
      .tick     (tick),
      .div_out  (div_out)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed per-cycle vector table plus reset/handshake corner sequences for clk_div_ctrl.
module tb_clk_div_ctrl;

   typedef struct {
      logic       en;
      logic       v;
      logic [7:0] p;
      logic [7:0] d;
      logic       e_div;
      logic       e_tick;
      logic       e_run;
      logic       e_rdy;
      logic       e_err;
   } vec_t;

   logic clk;
   logic reset;
   logic en;
   logic div_out;
   logic tick;
   logic running;
   int   n_cmp;
   int   n_bad;
   vec_t vecs[$];

   clk_div_ctrl_if #(.CNT_W(8)) cfg_bus ();

   clk_div_ctrl #(
      .CNT_W      (8),
      .DEF_PERIOD (5),
      .DEF_DUTY   (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .cfg     (cfg_bus.slave),
      .div_out (div_out),
      .tick    (tick),
      .running (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_div, input logic e_tick,
                            input logic e_run, input logic e_rdy, input logic e_err);
      check_output({tag, " div_out"},   div_out,           e_div);
      check_output({tag, " tick"},      tick,              e_tick);
      check_output({tag, " running"},   running,           e_run);
      check_output({tag, " cfg_ready"}, cfg_bus.cfg_ready, e_rdy);
      check_output({tag, " cfg_err"},   cfg_bus.cfg_err,   e_err);
   endtask

   task automatic apply_stimulus(input logic e, input logic v, input logic [7:0] p,
                                 input logic [7:0] d);
      en                 = e;
      cfg_bus.cfg_valid  = v;
      cfg_bus.cfg_period = p;
      cfg_bus.cfg_duty   = d;
   endtask

   function automatic void add(input logic e, input logic v, input logic [7:0] p,
                               input logic [7:0] d, input logic ed, input logic et,
                               input logic er, input logic ey, input logic ee);
      vec_t r;
      r.en = e; r.v = v; r.p = p; r.d = d;
      r.e_div = ed; r.e_tick = et; r.e_run = er; r.e_rdy = ey; r.e_err = ee;
      vecs.push_back(r);
   endfunction

   initial begin
      n_cmp = 0;
      n_bad = 0;

      // Each row: outputs expected at this falling edge, then inputs for the next rising edge.
      add(1,0,0,0, 0,0,0,1,0);
      add(1,0,0,0, 1,0,1,1,0);
      add(1,0,0,0, 0,0,1,1,0);
      add(1,0,0,0, 0,0,1,1,0);
      add(1,0,0,0, 0,0,1,1,0);
      add(1,0,0,0, 0,1,1,1,0);
      add(1,0,0,0, 1,0,1,1,0);
      add(1,0,0,0, 0,0,1,1,0);
      add(1,1,4,2, 0,0,1,1,0);
      add(1,0,0,0, 0,0,1,0,0);
      add(1,0,0,0, 0,1,1,0,0);
      add(1,0,0,0, 1,0,1,1,0);
      add(1,0,0,0, 1,0,1,1,0);
      add(1,0,0,0, 0,0,1,1,0);
      add(1,0,0,0, 0,1,1,1,0);
      add(1,1,1,0, 1,0,1,1,0);
      add(1,1,5,6, 1,0,1,1,1);
      add(1,0,0,0, 0,0,1,1,1);
      add(1,0,0,0, 0,1,1,1,0);
      add(1,1,3,3, 1,0,1,1,0);
      add(1,0,0,0, 1,0,1,0,0);
      add(1,0,0,0, 0,0,1,0,0);
      add(1,0,0,0, 0,1,1,0,0);
      add(1,0,0,0, 1,0,1,1,0);
      add(1,0,0,0, 1,0,1,1,0);
      add(1,1,3,0, 1,1,1,1,0);
      add(1,0,0,0, 1,0,1,0,0);
      add(1,0,0,0, 1,0,1,0,0);
      add(1,0,0,0, 1,1,1,0,0);
      add(1,0,0,0, 0,0,1,1,0);
      add(1,0,0,0, 0,0,1,1,0);
      add(1,0,0,0, 0,1,1,1,0);
      add(1,0,0,0, 0,0,1,1,0);
      add(0,0,0,0, 0,0,1,1,0);
      add(0,0,0,0, 0,1,1,1,0);
      add(0,0,0,0, 0,0,0,1,0);
      add(0,0,0,0, 0,0,0,1,0);

      reset = 1'b0;
      apply_stimulus(0, 0, 0, 0);
      #1;
      check_all("reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         check_all($sformatf("row%0d", i), vecs[i].e_div, vecs[i].e_tick,
                   vecs[i].e_run, vecs[i].e_rdy, vecs[i].e_err);
         apply_stimulus(vecs[i].en, vecs[i].v, vecs[i].p, vecs[i].d);
         @(negedge clk);
      end

      // Start and configure in the same idle cycle, then queue a config and reset in PEND.
      apply_stimulus(1, 1, 4, 2);
      @(negedge clk);
      check_all("start_cfg", 1, 0, 1, 1, 0);
      apply_stimulus(1, 1, 6, 3);
      @(negedge clk);
      check_all("pend_c1", 1, 0, 1, 0, 0);
      apply_stimulus(1, 0, 0, 0);
      @(negedge clk);
      check_all("pend_c2", 0, 0, 1, 0, 0);
      @(negedge clk);
      check_all("pend_c3", 0, 1, 1, 0, 0);
      reset = 1'b0;
      #1;
      check_all("async_rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check_all($sformatf("post_rst%0d", i), (i % 5) == 0, (i % 5) == 4, 1, 1, 0);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
